// File: rtl/timer_irq_if.sv
// Peripheral bus port of the timer/interrupt block: single-cycle request, one-cycle ack.
interface timer_irq_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        ack_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rdata_o, ack_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rdata_o, ack_o
    );
endinterface

// File: rtl/timer_irq.sv
// Machine timer (prescaled 64-bit mtime/mtimecmp) plus UART pending bit, encoded to one interrupt code.
// Bus ack one cycle after request, never stalls; int_flag_o registered, frozen while the arbiter is busy.
module timer_irq #(
    parameter logic [31:0]      BASE_ADDR  = 32'h1000_0000,
    parameter int               INT_W      = 8,
    parameter logic [INT_W-1:0] CODE_NONE  = 8'h00,
    parameter logic [INT_W-1:0] CODE_TIMER = 8'h01,
    parameter logic [INT_W-1:0] CODE_UART  = 8'h02
) (
    input  logic             clk,
    input  logic             rst_n,
    timer_irq_if.slave       bus,
    input  logic             uart_irq_i,
    input  logic             clint_busy_i,
    output logic [INT_W-1:0] int_flag_o
);

    localparam logic [3:0] OFF_CTRL  = 4'h0;
    localparam logic [3:0] OFF_PRESC = 4'h1;
    localparam logic [3:0] OFF_MTL   = 4'h2;
    localparam logic [3:0] OFF_MTH   = 4'h3;
    localparam logic [3:0] OFF_CML   = 4'h4;
    localparam logic [3:0] OFF_CMH   = 4'h5;
    localparam logic [3:0] OFF_STAT  = 4'h6;

    logic [3:0]       ctrl;
    logic [15:0]      prescale;
    logic [15:0]      div;
    logic [63:0]      mtime;
    logic [63:0]      mtimecmp;
    logic             tip;
    logic             uip;
    logic             ack_q;
    logic [31:0]      rdata_q;
    logic [INT_W-1:0] flag_q;

    logic       in_win;
    logic       acc;
    logic       wr;
    logic [3:0] off;
    logic       en;
    logic       hit;
    logic       tick;
    logic       clr_tip;
    logic       clr_uip;
    logic [31:0] rd_val;
    logic       unused_addr;

    assign unused_addr = ^bus.addr_i[1:0];

    assign in_win  = (bus.addr_i[31:6] == BASE_ADDR[31:6]);
    assign acc     = bus.req_i & in_win;
    assign wr      = acc & bus.we_i;
    assign off     = bus.addr_i[5:2];
    assign en      = ctrl[0];
    assign hit     = en & (mtime >= mtimecmp);
    assign tick    = en & (div == prescale);
    assign clr_tip = wr & (off == OFF_STAT) & bus.wdata_i[0];
    assign clr_uip = wr & (off == OFF_STAT) & bus.wdata_i[1];

    always_comb begin
        rd_val = 32'd0;
        case (off)
            OFF_CTRL:  rd_val = {28'd0, ctrl};
            OFF_PRESC: rd_val = {16'd0, prescale};
            OFF_MTL:   rd_val = mtime[31:0];
            OFF_MTH:   rd_val = mtime[63:32];
            OFF_CML:   rd_val = mtimecmp[31:0];
            OFF_CMH:   rd_val = mtimecmp[63:32];
            OFF_STAT:  rd_val = {30'd0, uip, tip};
            default:   rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            ctrl     <= 4'd0;
            prescale <= 16'd0;
            div      <= 16'd0;
            mtime    <= 64'd0;
            mtimecmp <= '1;
            tip      <= 1'b0;
            uip      <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= 32'd0;
            flag_q   <= CODE_NONE;
        end else begin
            ack_q   <= acc;
            rdata_q <= (acc && !bus.we_i) ? rd_val : 32'd0;

            if (wr && off == OFF_CTRL)  ctrl            <= bus.wdata_i[3:0];
            if (wr && off == OFF_PRESC) prescale        <= bus.wdata_i[15:0];
            if (wr && off == OFF_CML)   mtimecmp[31:0]  <= bus.wdata_i;
            if (wr && off == OFF_CMH)   mtimecmp[63:32] <= bus.wdata_i;

            // A software load of mtime beats the increment and restarts the divider.
            if (wr && (off == OFF_MTL || off == OFF_MTH)) begin
                if (off == OFF_MTL) mtime[31:0]  <= bus.wdata_i;
                else                mtime[63:32] <= bus.wdata_i;
                div <= 16'd0;
            end else if (tick) begin
                div   <= 16'd0;
                mtime <= (ctrl[1] && hit) ? 64'd0 : mtime + 64'd1;
            end else if (wr && off == OFF_PRESC) begin
                div <= 16'd0;
            end else if (en) begin
                div <= div + 16'd1;
            end

            // Set has priority over write-1-to-clear for both pending bits.
            tip <= hit | (tip & ~clr_tip);
            uip <= uart_irq_i | (uip & ~clr_uip);

            if (!clint_busy_i) begin
                if (tip && ctrl[2])      flag_q <= CODE_TIMER;
                else if (uip && ctrl[3]) flag_q <= CODE_UART;
                else                     flag_q <= CODE_NONE;
            end
        end
    end

    assign bus.ack_o   = ack_q;
    assign bus.rdata_o = rdata_q;
    assign int_flag_o  = flag_q;

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench: reads push expected data into a queue, a monitor pops and compares on every ack.
module tb_timer_irq;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] CTRL = BASE + 32'h00;
    localparam logic [31:0] PRSC = BASE + 32'h04;
    localparam logic [31:0] MTL  = BASE + 32'h08;
    localparam logic [31:0] MTH  = BASE + 32'h0C;
    localparam logic [31:0] CML  = BASE + 32'h10;
    localparam logic [31:0] CMH  = BASE + 32'h14;
    localparam logic [31:0] STAT = BASE + 32'h18;
    localparam logic [31:0] GAP  = BASE + 32'h1C;
    localparam logic [31:0] OUTW = BASE + 32'h40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       uart = 1'b0;
    logic       busy = 1'b0;
    logic [7:0] flag;

    timer_irq_if bus_if();

    timer_irq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_if),
        .uart_irq_i   (uart),
        .clint_busy_i (busy),
        .int_flag_o   (flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk;
        logic [31:0] addr;
        logic [31:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic bus_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic track, input logic chk, input logic [31:0] e);
        exp_t x;
        bus_if.req_i   = 1'b1;
        bus_if.we_i    = w;
        bus_if.addr_i  = a;
        bus_if.wdata_i = d;
        x.chk  = chk;
        x.addr = a;
        x.dat  = e;
        if (track) exp_q.push_back(x);
        @(negedge clk);
        bus_if.req_i = 1'b0;
        bus_if.we_i  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_op(1'b1, a, d, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        bus_op(1'b0, a, 32'd0, 1'b1, 1'b1, e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus_if.ack_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk) check($sformatf("rd_%0h", e.addr), 64'(bus_if.rdata_o), 64'(e.dat));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stim
        bus_if.req_i   = 1'b0;
        bus_if.we_i    = 1'b0;
        bus_if.addr_i  = 32'd0;
        bus_if.wdata_i = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_flag", 64'(flag), 64'h00);
        check("rst_ack", 64'(bus_if.ack_o), 64'h0);
        check("rst_rdata", 64'(bus_if.rdata_o), 64'h0);
        rst_n = 1'b0;
        @(negedge clk);

        // 1: prescale 0, compare at 10
        wr(PRSC, 32'd0);
        wr(CML, 32'd10);
        wr(CMH, 32'd0);
        wr(CTRL, 32'h5);
        rd(MTL, 32'd0);
        rd(MTL, 32'd1);
        repeat (9) @(negedge clk);
        check("t1_flag_before", 64'(flag), 64'h00);
        rd(STAT, 32'h1);
        check("t1_flag_timer", 64'(flag), 64'h01);
        rd(MTL, 32'd12);
        wr(CTRL, 32'h0);
        rd(MTL, 32'd14);
        wr(STAT, 32'h1);
        rd(STAT, 32'h0);

        // 2: prescale 3, mid-count load restarts the divider
        wr(PRSC, 32'd3);
        wr(MTL, 32'd0);
        wr(CTRL, 32'h1);
        for (int j = 1; j <= 9; j++) rd(MTL, 32'((j - 1) / 4));
        wr(MTL, 32'd5);
        for (int k = 0; k < 5; k++) rd(MTL, (k < 4) ? 32'd5 : 32'd6);
        wr(CTRL, 32'h0);

        // 3: autoreload, clear during hit loses to set
        wr(PRSC, 32'd0);
        wr(MTL, 32'd0);
        wr(CML, 32'd3);
        wr(CTRL, 32'h3);
        for (int j = 1; j <= 7; j++) rd(MTL, 32'((j - 1) % 4));
        wr(STAT, 32'h1);
        rd(STAT, 32'h1);
        wr(CTRL, 32'h0);
        wr(STAT, 32'h1);
        rd(STAT, 32'h0);

        // 4: UART then timer, priority and clears
        wr(CML, 32'd0);
        wr(CTRL, 32'hC);
        uart = 1'b1;
        @(negedge clk);
        uart = 1'b0;
        check("t4_uart_lat", 64'(flag), 64'h00);
        @(negedge clk);
        check("t4_uart", 64'(flag), 64'h02);
        wr(CTRL, 32'hD);
        @(negedge clk);
        check("t4_timer_lat", 64'(flag), 64'h02);
        @(negedge clk);
        check("t4_timer_prio", 64'(flag), 64'h01);
        wr(CTRL, 32'hC);
        wr(STAT, 32'h1);
        check("t4_tip_clr_lat", 64'(flag), 64'h01);
        @(negedge clk);
        check("t4_back_uart", 64'(flag), 64'h02);
        wr(STAT, 32'h2);
        check("t4_uip_clr_lat", 64'(flag), 64'h02);
        @(negedge clk);
        check("t4_none", 64'(flag), 64'h00);
        uart = 1'b1;
        @(negedge clk);
        uart = 1'b1;
        wr(STAT, 32'h2);
        uart = 1'b0;
        rd(STAT, 32'h2);
        wr(STAT, 32'h2);
        rd(STAT, 32'h0);

        // 5: freeze while arbiter busy
        busy = 1'b1;
        wr(CTRL, 32'hD);
        repeat (4) @(negedge clk);
        check("t5_frozen", 64'(flag), 64'h00);
        busy = 1'b0;
        @(negedge clk);
        check("t5_release", 64'(flag), 64'h01);
        wr(CTRL, 32'h0);
        wr(STAT, 32'h3);

        // 6: wrap at all-ones, then reset
        wr(CML, 32'hFFFF_FFFF);
        wr(CMH, 32'hFFFF_FFFF);
        wr(MTL, 32'hFFFF_FFFE);
        wr(MTH, 32'hFFFF_FFFF);
        wr(CTRL, 32'h5);
        rd(MTL, 32'hFFFF_FFFE);
        rd(MTL, 32'hFFFF_FFFF);
        rd(MTL, 32'd0);
        rd(MTH, 32'd0);
        rd(STAT, 32'h1);
        check("t6_flag", 64'(flag), 64'h01);

        rst_n = 1'b1;
        bus_op(1'b0, MTL, 32'd0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b0;
        check("t6_ack_dropped", 64'(bus_if.ack_o), 64'h0);
        check("t6_flag_rst", 64'(flag), 64'h00);
        rd(CTRL, 32'd0);
        rd(PRSC, 32'd0);
        rd(MTL, 32'd0);
        rd(MTH, 32'd0);
        rd(CML, 32'hFFFF_FFFF);
        rd(CMH, 32'hFFFF_FFFF);
        rd(STAT, 32'd0);

        // unmapped offset and out-of-window access
        wr(GAP, 32'hDEAD_BEEF);
        rd(GAP, 32'd0);
        bus_op(1'b0, OUTW, 32'd0, 1'b0, 1'b0, 32'd0);
        bus_op(1'b1, OUTW, 32'h1234, 1'b0, 1'b0, 32'd0);
        rd(CTRL, 32'd0);

        repeat (3) @(negedge clk);
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/timer_irq.md
Name: timer_irq

Overview:
- Memory-mapped machine-timer and interrupt-source aggregator.
- Contains a 64-bit mtime counter with prescaler and a 64-bit mtimecmp.
- Latches the UART receive interrupt pulse into a pending bit.
- Drives the single encoded interrupt code consumed by the core-local interrupt arbiter as its async interrupt input. Sits on the peripheral bus directly upstream of that arbiter.

Parameters:
- BASE_ADDR, 32'h1000_0000, base of the register window (64 bytes, addr[5:2] select).
- INT_W, 8, width of the encoded interrupt code.
- CODE_NONE, 8'h00, code driven when nothing is pending/enabled.
- CODE_TIMER, 8'h01, code for the timer interrupt.
- CODE_UART, 8'h02, code for the UART receive interrupt.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-high (asserted = 1).
- req_i  in  1  bus request, single-cycle pulse.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  32  byte address.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data, valid with ack_o.
- ack_o  out  1  bus acknowledge, one cycle.
- uart_irq_i  in  1  UART receive interrupt, single-cycle pulse.
- clint_busy_i  in  1  arbiter busy; freezes int_flag_o.
- int_flag_o  out  INT_W  encoded pending interrupt to the arbiter.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x00 CTRL, rw: bit0 EN, bit1 AUTORELOAD, bit2 TIE, bit3 UIE. Unused bits read 0.
  - 0x04 PRESCALE, rw 16 bits [15:0].
  - 0x08 MTIME_LO, rw.
  - 0x0C MTIME_HI, rw.
  - 0x10 MTIMECMP_LO, rw.
  - 0x14 MTIMECMP_HI, rw.
  - 0x18 STATUS: bit0 TIP, bit1 UIP. Write-1-to-clear.
  - Other offsets inside the window: read 0, writes ignored. Addresses outside the window: no ack.
- Reset values: CTRL 0, PRESCALE 0, MTIME 0, MTIMECMP all-ones (64'hFFFF_FFFF_FFFF_FFFF), TIP 0, UIP 0, rdata_o 0, ack_o 0, int_flag_o CODE_NONE.
- Bus:
  - ack_o asserts exactly one cycle after an in-window req_i and carries rdata_o; rdata_o returns 0 in cycles without ack.
  - Writes take effect on the req_i cycle edge, so a read issued in the next cycle sees the new value.
  - Back-to-back requests are accepted every cycle.
- Prescaler:
  - 16-bit divider counter. While EN=1 it counts 0..PRESCALE.
  - mtime increments by 1 on the cycle the divider equals PRESCALE; the divider then returns to 0. PRESCALE=0 means mtime increments every cycle.
  - EN=0 holds both the divider and mtime.
  - A write to PRESCALE resets the divider to 0.
- mtime:
  - 64-bit, wraps from all-ones to 0.
  - A bus write to MTIME_LO/HI wins over the increment in the same cycle and also resets the divider.
- Compare:
  - hit = EN & (mtime >= mtimecmp), 64-bit unsigned.
  - On hit, TIP is set the following cycle.
  - If AUTORELOAD=1, mtime loads 0 on the hit increment instead of incrementing.
  - TIP is sticky until written 1 at STATUS bit0. If hit is still true in the clear cycle, set wins.
  - Writing MTIMECMP does not clear TIP.
- UART:
  - uart_irq_i=1 sets UIP next cycle. Sticky until W1C at STATUS bit1.
  - A pulse coincident with the clear cycle keeps UIP set.
- Output encode, registered, 1-cycle latency from pending/enable change:
  - TIP & TIE → CODE_TIMER.
  - else UIP & UIE → CODE_UART.
  - else CODE_NONE.
  - Timer has priority over UART.
- Freeze: while clint_busy_i=1, int_flag_o holds its previous value. It updates on the first cycle after busy falls.
- Reset mid-operation (rst_n=1 on any edge): all state returns to reset values; an in-flight ack is dropped.

Test Plan:
1. PRESCALE=0, MTIMECMP=10, CTRL=0x5 (EN, TIE) → mtime counts 1/cycle; TIP set at mtime=10; int_flag_o=0x01 one cycle later; STATUS reads 0x1.
2. PRESCALE=3, EN=1 → mtime increments every 4 cycles. Write MTIME_LO=5 mid-count → next read returns 5 and the divider restarts.
3. AUTORELOAD=1, MTIMECMP=3, PRESCALE=0 → mtime sequence 0,1,2,3,0,1…; TIP set; W1C STATUS=0x1 while mtime=3 → TIP stays 1 (set wins).
4. UIE=1, TIE=1, uart_irq_i pulse then timer hit → int_flag_o 0x02 then 0x01. Clear TIP → 0x02. Clear UIP → 0x00.
5. clint_busy_i=1 while TIP becomes set → int_flag_o stays 0x00; busy drops → 0x01 next cycle.
6. MTIME=64'hFFFF_FFFF_FFFF_FFFE, MTIMECMP=all-ones, EN=1 → TIP sets at all-ones; mtime wraps to 0. Assert rst_n for 1 cycle → all registers at reset values, ack_o=0.
